// File: rtl/and_or_tester.sv
// Stimulus/response checker for the 4-input AND-OR gate family.
// Walks all 16 vectors, compares against (in1&in2)|(in3&in4).
module and_or_tester #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_out,
  output logic [3:0]       dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_err_vec,
  output logic             first_err_valid
);

  localparam int SCW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] LOAD =
    SCW'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  state_e           state_q;
  logic [3:0]       vec_q;
  logic [SCW-1:0]   cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [3:0]       fev_q;
  logic             fval_q;
  logic             busy_q;
  logic             done_q;
  logic             exp_bit;
  logic             mismatch;

  // Golden reference and saturating error increment.
  always_comb begin
    exp_bit  = (vec_q[3] & vec_q[2]) | (vec_q[1] & vec_q[0]);
    mismatch = exp_bit ^ dut_out;
    err_d    = err_q;
    if (err_q != ERR_MAX) begin
      err_d = err_q + 1'b1;
    end
  end

  // Run sequencer: settle each vector, then sample and score it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fev_q   <= '0;
      fval_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            vec_q   <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fval_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= LOAD;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q - SCW'(1);
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_q <= err_d;
            if (!fval_q) begin
              fev_q  <= vec_q;
              fval_q <= 1'b1;
            end
          end
          if (vec_q == 4'hF) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            vec_q   <= vec_q + 4'd1;
            cnt_q   <= LOAD;
            state_q <= SETTLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dut_in          = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = done_q & (err_q == '0);
  assign err_cnt         = err_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fval_q;

endmodule

// File: tb/tb_and_or_tester.sv
// Bench for and_or_tester: two instances (settle 1 and 3)
// driven against ideal, stuck, inverted and delayed gate models.
module tb_and_or_tester;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_s [2];
  logic       dout    [2];
  logic [3:0] din     [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       pass_w  [2];
  logic [4:0] err_w   [2];
  logic [3:0] fev_w   [2];
  logic       fval_w  [2];
  logic       d1      [2];
  logic       d2      [2];
  int         mode    [2];

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  and_or_tester #(.SETTLE_CYCLES(1), .ERR_W(5)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]),
    .dut_out(dout[0]), .dut_in(din[0]), .busy(busy_w[0]),
    .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0]),
    .first_err_vec(fev_w[0]), .first_err_valid(fval_w[0])
  );

  and_or_tester #(.SETTLE_CYCLES(3), .ERR_W(5)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]),
    .dut_out(dout[1]), .dut_in(din[1]), .busy(busy_w[1]),
    .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1]),
    .first_err_vec(fev_w[1]), .first_err_valid(fval_w[1])
  );

  function automatic logic f_ao(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  // Two-cycle delayed gate model.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      d1[u] <= f_ao(din[u]);
      d2[u] <= d1[u];
    end
  end

  // Gate model selection: 0 ideal, 1 stuck0, 2 stuck1, 3 inverted, 4 delay2.
  always_comb begin
    for (int u = 0; u < 2; u++) begin
      dout[u] = 1'b0;
      case (mode[u])
        0: dout[u] = f_ao(din[u]);
        1: dout[u] = 1'b0;
        2: dout[u] = 1'b1;
        3: dout[u] = ~f_ao(din[u]);
        default: dout[u] = d2[u];
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end else begin
      passed++;
    end
  endtask

  typedef struct {
    int u;
    int md;
    int e_err;
    int e_fev;
    int e_fval;
    int e_pass;
    int e_cyc;
    bit repulse;
  } row_t;

  row_t tbl [7];

  task automatic run_row(input row_t r);
    int u;
    int s;
    int cyc;
    int seq_bad;
    int pb_bad;
    int ev;
    u = r.u;
    s = (u == 0) ? 1 : 3;
    mode[u] = r.md;
    cyc = 0;
    seq_bad = 0;
    pb_bad = 0;
    @(negedge clk);
    start_s[u] = 1'b1;
    @(posedge clk);
    #1;
    start_s[u] = 1'b0;
    chk("busy_after_start", 32'(busy_w[u]), 1);
    chk("done_after_start", 32'(done_w[u]), 0);
    chk("din_after_start", 32'(din[u]), 0);
    chk("err_after_start", 32'(err_w[u]), 0);
    chk("fval_after_start", 32'(fval_w[u]), 0);
    for (int k = 1; k <= r.e_cyc + 20; k++) begin
      if (r.repulse && k == 10) start_s[u] = 1'b1;
      @(posedge clk);
      #1;
      start_s[u] = 1'b0;
      if (done_w[u]) begin
        cyc = k;
        break;
      end
      ev = k / (s + 1);
      if (ev > 15) ev = 15;
      if (din[u] != 4'(ev)) seq_bad++;
      if (!busy_w[u]) seq_bad++;
      if (pass_w[u]) pb_bad++;
    end
    chk("done_cycle", cyc, r.e_cyc);
    chk("vector_sequence", seq_bad, 0);
    chk("pass_while_busy", pb_bad, 0);
    chk("err_cnt", 32'(err_w[u]), r.e_err);
    chk("first_err_vec", 32'(fev_w[u]), r.e_fev);
    chk("first_err_valid", 32'(fval_w[u]), r.e_fval);
    chk("pass", 32'(pass_w[u]), r.e_pass);
    chk("busy_at_done", 32'(busy_w[u]), 0);
    chk("din_at_done", 32'(din[u]), 15);
  endtask

  initial begin
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    mode[0] = 0;
    mode[1] = 0;
    // u, mode, err, fev, fval, pass, cycles, repulse
    tbl[0] = '{0, 0, 0, 0, 0, 1, 32, 1'b0};
    tbl[1] = '{0, 1, 7, 3, 1, 0, 32, 1'b0};
    tbl[2] = '{0, 0, 0, 0, 0, 1, 32, 1'b0};
    tbl[3] = '{0, 2, 9, 0, 1, 0, 32, 1'b0};
    tbl[4] = '{0, 3, 16, 0, 1, 0, 32, 1'b1};
    tbl[5] = '{1, 4, 0, 0, 0, 1, 64, 1'b0};
    // settle 1 against delay2; pre-run output is f(15)=1, so
    // vectors 0,3,4,7,8,11 see the previous vector's value
    tbl[6] = '{0, 4, 6, 0, 1, 0, 32, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_din", 32'(din[0]), 0);
    chk("rst_busy", 32'(busy_w[0]), 0);
    chk("rst_done", 32'(done_w[0]), 0);
    chk("rst_pass", 32'(pass_w[0]), 0);
    chk("rst_err", 32'(err_w[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_row(tbl[i]);
    end

    // Asynchronous abort mid-run with stuck-at-0 gate.
    mode[0] = 1;
    @(negedge clk);
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    chk("mid_fval", 32'(fval_w[0]), 1);
    chk("mid_err", 32'(err_w[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_din", 32'(din[0]), 0);
    chk("abort_busy", 32'(busy_w[0]), 0);
    chk("abort_done", 32'(done_w[0]), 0);
    chk("abort_pass", 32'(pass_w[0]), 0);
    chk("abort_err", 32'(err_w[0]), 0);
    chk("abort_fev", 32'(fev_w[0]), 0);
    chk("abort_fval", 32'(fval_w[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy_w[0]), 0);
    chk("idle_done", 32'(done_w[0]), 0);
    chk("idle_din", 32'(din[0]), 0);
    run_row(tbl[1]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
